sync_debounce: RTL



---
 rtl/sync_debounce.sv | 87 ++++++++
 1 files changed

// File: rtl/sync_debounce.sv
// sync_debounce: per-bit debouncer with registered rise/fall edge pulses.
//
// Each bit of the already-synchronized input d must differ from the current
// debounced level for STABLE_CYCLES consecutive clocks before that level
// flips. The flip is accompanied by a one-cycle rise or fall pulse.
//
// Ports:
//   clk      system clock, all state changes on posedge
//   rst      asynchronous, active-high reset
//   d        synchronized input bus (WIDTH bits), no synchronization here
//   q        debounced level (registered)
//   rise     one-cycle pulse per bit on q[i] 0->1 (registered)
//   fall     one-cycle pulse per bit on q[i] 1->0 (registered)
//   changed  OR of rise|fall, high in the same cycle as any pulse (registered)
module sync_debounce #(
    parameter int unsigned      WIDTH         = 4,
    parameter int unsigned      STABLE_CYCLES = 16,
    parameter logic [WIDTH-1:0] INIT          = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             changed
);

    localparam int unsigned      CNT_W    = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    if (STABLE_CYCLES < 1) begin : g_bad_stable_cycles
        $error("sync_debounce: STABLE_CYCLES must be >= 1");
    end

    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic             changed_q, changed_d;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];

    // Per-bit run counter of samples differing from the debounced level.
    // A matching sample clears the run, which is what rejects glitches.
    always_comb begin
        q_d    = q_q;
        rise_d = '0;
        fall_d = '0;
        cnt_d  = cnt_q;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (d[i] == q_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                q_d[i]    = d[i];
                cnt_d[i]  = '0;
                rise_d[i] = d[i];
                fall_d[i] = ~d[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
        changed_d = |(rise_d | fall_d);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q       <= INIT;
            rise_q    <= '0;
            fall_q    <= '0;
            changed_q <= 1'b0;
            cnt_q     <= '{default: '0};
        end else begin
            q_q       <= q_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            changed_q <= changed_d;
            cnt_q     <= cnt_d;
        end
    end

    assign q       = q_q;
    assign rise    = rise_q;
    assign fall    = fall_q;
    assign changed = changed_q;

endmodule
